// File: rtl/imem_program_loader.sv
// imem_program_loader: receives a length-prefixed byte stream, packs it into
// WL-bit words (little-endian) and writes them sequentially into the
// instruction memory. The CPU is held in reset until a full program is loaded.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle pulse that begins a load session
//   byte_in/valid     incoming stream byte and its qualifier
//   byte_ready        loader can accept a byte this cycle
//   imem_we/waddr/wdata  instruction memory write port (one pulse per word)
//   cpu_hold          high keeps the CPU in reset
//   load_done         program loaded successfully
//   load_err          header word count exceeded DEPTH
//   words_written     words written in the current session
module imem_program_loader #(
  parameter int unsigned WL    = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [WL-1:0] imem_wdata,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err,
  output logic [15:0]   words_written
);

  localparam int unsigned BPW = WL / 8;
  localparam int unsigned BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned CW  = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q;
  logic [BIW-1:0] byte_idx_q;
  logic [AW-1:0]  word_idx_q;
  logic [WL-1:0]  word_buf_q;
  logic [WL-1:0]  word_asm;
  logic [CW-1:0]  len_full;
  logic [CW-1:0]  words_inc;
  logic           accept;
  logic           last_byte;
  logic           session_start;
  logic           ready_d, we_d, hold_d, done_d, err_d;

  assign accept        = byte_valid && byte_ready;
  assign last_byte     = (32'(byte_idx_q) == BPW - 1);
  assign len_full      = {byte_in, count_q[7:0]};
  assign words_inc     = words_written + CW'(1);
  assign session_start = start && (state_q inside {S_IDLE, S_DONE, S_ERROR});

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_LO;
      S_LEN_LO: if (accept) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (len_full == '0)              state_d = S_DONE;
          else if (32'(len_full) > DEPTH)  state_d = S_ERROR;
          else                             state_d = S_DATA;
        end
      end
      S_DATA:  if (accept && last_byte) state_d = S_WRITE;
      S_WRITE: state_d = (words_inc == count_q) ? S_DONE : S_DATA;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state; registered below so outputs track state
  always_comb begin
    ready_d = 1'b0;
    we_d    = 1'b0;
    hold_d  = 1'b1;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_d)
      S_LEN_LO, S_LEN_HI, S_DATA: ready_d = 1'b1;
      S_WRITE: we_d = 1'b1;
      S_DONE: begin
        hold_d = 1'b0;
        done_d = 1'b1;
      end
      S_ERROR: err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      byte_ready <= ready_d;
      imem_we    <= we_d;
      cpu_hold   <= hold_d;
      load_done  <= done_d;
      load_err   <= err_d;
    end
  end

  // Current word with the incoming byte dropped into its little-endian lane
  always_comb begin
    word_asm = word_buf_q;
    for (int k = 0; k < int'(BPW); k++) begin
      if (byte_idx_q == BIW'(k)) word_asm[8*k +: 8] = byte_in;
    end
  end

  // Datapath: header capture, word assembly, write port and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q       <= '0;
      byte_idx_q    <= '0;
      word_idx_q    <= '0;
      word_buf_q    <= '0;
      imem_waddr    <= '0;
      imem_wdata    <= '0;
      words_written <= '0;
    end else begin
      if (session_start) begin
        count_q       <= '0;
        byte_idx_q    <= '0;
        word_idx_q    <= '0;
        words_written <= '0;
      end
      if (state_q == S_LEN_LO && accept) count_q[7:0]  <= byte_in;
      if (state_q == S_LEN_HI && accept) count_q[15:8] <= byte_in;
      if (state_q == S_DATA && accept) begin
        word_buf_q <= word_asm;
        byte_idx_q <= last_byte ? '0 : byte_idx_q + BIW'(1);
        if (last_byte) begin
          imem_wdata <= word_asm;
          imem_waddr <= word_idx_q;
        end
      end
      if (state_q == S_WRITE) begin
        word_idx_q    <= word_idx_q + AW'(1);
        words_written <= words_inc;
        byte_idx_q    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed testbench for imem_program_loader.
module tb_imem_program_loader;

  localparam int unsigned WL    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [WL-1:0] imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [15:0]   words_written;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] wr_addr[$];
  logic [WL-1:0] wr_data[$];
  logic          rdy_chk = 1'b0;
  int            rdy_viol = 0;

  logic [7:0] stream [10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                              8'hEF, 8'hBE, 8'hAD, 8'hDE};

  imem_program_loader #(.WL(WL), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdata    (imem_wdata),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
    .load_err      (load_err),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  // Capture every write; flag byte_ready dropping outside a write cycle
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_waddr);
      wr_data.push_back(imem_wdata);
    end
    if (rdy_chk && (byte_ready === imem_we)) rdy_viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Present one byte and hold it until the loader accepts it (bounded)
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte_ready=%b required 1", byte_ready);
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (cpu_hold !== 1'b1)   begin errors++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready: got %b want 0", byte_ready); end
    checks++; if (imem_we !== 1'b0)    begin errors++; $display("FAIL reset_imem_we: got %b want 0", imem_we); end
    checks++; if (load_done !== 1'b0)  begin errors++; $display("FAIL reset_load_done: got %b want 0", load_done); end
    checks++; if (load_err !== 1'b0)   begin errors++; $display("FAIL reset_load_err: got %b want 0", load_err); end
    checks++; if (words_written !== 16'd0) begin errors++; $display("FAIL reset_words: got %0d want 0", words_written); end
    checks++; if (imem_wdata !== 32'h0 || imem_waddr !== 8'h0) begin
      errors++; $display("FAIL reset_wport: addr=%h data=%h want 0/0", imem_waddr, imem_wdata);
    end
    checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL reset_no_writes: got %0d want 0", wr_addr.size()); end
  endtask

  task automatic test_basic();
    clear_log();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(stream[i]);
    // The edge that accepted the last byte entered WRITE
    checks++; if (imem_we !== 1'b1 || imem_waddr !== 8'd1 || imem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_write_latency: we=%b addr=%h data=%h want 1/01/deadbeef", imem_we, imem_waddr, imem_wdata);
    end
    tick();
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL basic_load_done: got %b want 1", load_done); end
    checks++; if (cpu_hold !== 1'b0)  begin errors++; $display("FAIL basic_cpu_hold: got %b want 0", cpu_hold); end
    checks++; if (words_written !== 16'd2) begin errors++; $display("FAIL basic_words: got %0d want 2", words_written); end
    checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL basic_write_count: got %0d want 2", wr_addr.size()); end
    checks++; if (wr_addr.size() < 2 || wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h12345678) begin
      errors++; $display("FAIL basic_word0: got n=%0d want addr 00 data 12345678", wr_addr.size());
    end
    checks++; if (wr_addr.size() < 2 || wr_addr[1] !== 8'd1 || wr_data[1] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_word1: got n=%0d want addr 01 data deadbeef", wr_addr.size());
    end
    repeat (2) tick();
    checks++; if (imem_we !== 1'b0 || imem_wdata !== 32'hDEADBEEF || imem_waddr !== 8'd1) begin
      errors++; $display("FAIL basic_hold_wport: we=%b addr=%h data=%h want 0/01/deadbeef", imem_we, imem_waddr, imem_wdata);
    end
  endtask

  task automatic test_gaps();
    clear_log();
    rdy_viol = 0;
    pulse_start();
    checks++; if (cpu_hold !== 1'b1 || load_done !== 1'b0 || byte_ready !== 1'b1) begin
      errors++; $display("FAIL gaps_reload: hold=%b done=%b ready=%b want 1/0/1", cpu_hold, load_done, byte_ready);
    end
    send_byte(stream[0]);
    repeat (3) tick();
    send_byte(stream[1]);
    rdy_chk = 1'b1;
    for (int i = 2; i < 10; i++) begin
      repeat (3) tick();
      send_byte(stream[i]);
    end
    tick();
    rdy_chk = 1'b0;
    checks++; if (rdy_viol != 0) begin errors++; $display("FAIL gaps_ready_only_in_write: got %0d bad cycles want 0", rdy_viol); end
    checks++; if (load_done !== 1'b1 || words_written !== 16'd2) begin
      errors++; $display("FAIL gaps_done: done=%b words=%0d want 1/2", load_done, words_written);
    end
    checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL gaps_write_count: got %0d want 2", wr_addr.size()); end
    checks++; if (wr_addr.size() < 2 || wr_data[0] !== 32'h12345678 || wr_data[1] !== 32'hDEADBEEF
                  || wr_addr[0] !== 8'd0 || wr_addr[1] !== 8'd1) begin
      errors++; $display("FAIL gaps_words: got n=%0d want 12345678@00 deadbeef@01", wr_addr.size());
    end
  endtask

  task automatic test_error();
    clear_log();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    checks++; if (load_err !== 1'b1)   begin errors++; $display("FAIL err_flag: got %b want 1", load_err); end
    checks++; if (cpu_hold !== 1'b1)   begin errors++; $display("FAIL err_cpu_hold: got %b want 1", cpu_hold); end
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL err_byte_ready: got %b want 0", byte_ready); end
    checks++; if (load_done !== 1'b0)  begin errors++; $display("FAIL err_load_done: got %b want 0", load_done); end
    repeat (5) tick();
    checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL err_no_writes: got %0d want 0", wr_addr.size()); end
    pulse_start();
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL err_clear_on_start: got %b want 0", load_err); end
    send_byte(8'h00);
    send_byte(8'h00);
    checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0 || load_err !== 1'b0) begin
      errors++; $display("FAIL zero_len_done: done=%b hold=%b err=%b want 1/0/0", load_done, cpu_hold, load_err);
    end
    repeat (2) tick();
    checks++; if (words_written !== 16'd0 || wr_addr.size() != 0) begin
      errors++; $display("FAIL zero_len_writes: words=%0d writes=%0d want 0/0", words_written, wr_addr.size());
    end
  endtask

  task automatic test_full_depth();
    int bad;
    logic [WL-1:0] exp;
    clear_log();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    for (int i = 0; i < 4 * int'(DEPTH); i++) send_byte(8'(i));
    checks++; if (imem_we !== 1'b1 || imem_waddr !== 8'd255 || load_done !== 1'b0) begin
      errors++; $display("FAIL full_last_write: we=%b addr=%h done=%b want 1/ff/0", imem_we, imem_waddr, load_done);
    end
    tick();
    checks++; if (load_done !== 1'b1 || words_written !== 16'd256) begin
      errors++; $display("FAIL full_done: done=%b words=%0d want 1/256", load_done, words_written);
    end
    checks++; if (wr_addr.size() != int'(DEPTH)) begin
      errors++; $display("FAIL full_write_count: got %0d want %0d", wr_addr.size(), DEPTH);
    end
    bad = 0;
    for (int w = 0; w < wr_addr.size(); w++) begin
      exp = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      if (wr_addr[w] !== 8'(w) || wr_data[w] !== exp) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL full_contents: got %0d bad words want 0", bad); end
    checks++; if (wr_addr.size() == 0 || wr_addr[wr_addr.size()-1] !== 8'd255) begin
      errors++; $display("FAIL full_final_addr: got n=%0d want last addr ff", wr_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (cpu_hold !== 1'b1 || load_done !== 1'b0 || byte_ready !== 1'b0 || words_written !== 16'd0) begin
      errors++; $display("FAIL midrst_state: hold=%b done=%b ready=%b words=%0d want 1/0/0/0",
                         cpu_hold, load_done, byte_ready, words_written);
    end
    repeat (2) tick();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    tick();
    checks++; if (load_done !== 1'b1 || words_written !== 16'd1) begin
      errors++; $display("FAIL midrst_done: done=%b words=%0d want 1/1", load_done, words_written);
    end
    checks++; if (wr_addr.size() != 1) begin errors++; $display("FAIL midrst_write_count: got %0d want 1", wr_addr.size()); end
    checks++; if (wr_addr.size() < 1 || wr_addr[0] !== 8'd0 || wr_data[0] !== 32'hDDCCBBAA) begin
      errors++; $display("FAIL midrst_word: got n=%0d want ddccbbaa@00", wr_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_error();
    test_full_depth();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer-side companion to the instruction memory: receives a byte stream (length header plus program words) and writes assembled instruction words sequentially into the memory's write port.
- Holds the CPU in reset (cpu_hold) until a complete program has been loaded.
- Sits between a byte source (UART receiver or testbench) and the instruction memory write port.

Parameters:
WL, 32, instruction word width in bits; must be a multiple of 8; BPW = WL/8 bytes per word
DEPTH, 256, number of instruction words in memory (WL*8 at default)
AW, 8, address width; 2^AW >= DEPTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  single-cycle pulse that begins a load session
byte_in  input  8  incoming stream byte
byte_valid  input  1  byte_in is valid this cycle
byte_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  instruction memory write enable, one-cycle pulse per word
imem_waddr  output  AW  word address for the write
imem_wdata  output  WL  assembled instruction word
cpu_hold  output  1  high = keep CPU in reset
load_done  output  1  program loaded successfully
load_err  output  1  header word count exceeded DEPTH
words_written  output  16  number of words written in the current session

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- A byte is accepted on a rising edge where byte_valid && byte_ready. byte_in is ignored otherwise.
- Reset state (rst_n=0 at an edge):
  - FSM goes to IDLE.
  - byte_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_hold=1, load_done=0, load_err=0, words_written=0.
  - Reset mid-session abandons the load. Memory contents are not cleared.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR.
- IDLE:
  - byte_ready=0.
  - start -> LEN_LO; clears words_written, byte index, word index, load_done, load_err.
- LEN_LO:
  - byte_ready=1.
  - Accepted byte -> count[7:0]; go to LEN_HI.
- LEN_HI:
  - byte_ready=1.
  - Accepted byte -> count[15:8]. Next state depends on the full 16-bit count:
    - count==0 -> DONE
    - count>DEPTH -> ERROR
    - otherwise -> DATA
- DATA:
  - byte_ready=1.
  - Bytes are packed little-endian: byte k of the word (k=0..BPW-1) goes into wdata[8k+7:8k].
  - Acceptance of byte BPW-1 -> WRITE.
- WRITE (exactly one cycle):
  - imem_we=1; imem_waddr = current word index; imem_wdata = assembled word; byte_ready=0.
  - On exit: word index increments, words_written increments, byte index returns to 0.
  - If words_written (after increment) == count -> DONE; else -> DATA.
- DONE:
  - load_done=1, cpu_hold=0, byte_ready=0.
  - start -> LEN_LO (reload): cpu_hold reasserts and load_done clears the next cycle.
- ERROR:
  - load_err=1, cpu_hold=1, byte_ready=0. No memory writes occur.
  - start -> LEN_LO.
- Outputs by state:
  - cpu_hold = 1 in every state except DONE.
  - imem_we = 0 in every state except WRITE.
- start is ignored in LEN_LO, LEN_HI, DATA and WRITE.
- byte_valid gaps of any length stall the FSM without data loss. Partial words are held indefinitely.
- Bytes presented while byte_ready=0 are not consumed; the source holds them.
- Latency: the word write occurs the cycle after its last byte is accepted. Maximum sustained rate is BPW bytes per BPW+1 cycles.
- count==DEPTH is legal: the final write goes to address DEPTH-1. Address never wraps.
- imem_wdata and imem_waddr are registered outputs and hold their last values outside WRITE.

Test Plan:
- Reset, then idle 5 cycles -> cpu_hold=1, byte_ready=0, imem_we=0, load_done=0, load_err=0.
- start; bytes 02 00, then 78 56 34 12, then EF BE AD DE -> two imem_we pulses: addr0=0x12345678, addr1=0xDEADBEEF; load_done=1, cpu_hold=0, words_written=2.
- Same stream with byte_valid low for 3 cycles between every byte -> identical writes; byte_ready drops only during WRITE cycles.
- start; header 01 01 (257 > DEPTH) -> load_err=1, cpu_hold=1, no imem_we; then start with header 00 00 -> load_done=1 with zero writes.
- Header 00 01 (256), then 1024 incrementing bytes -> 256 writes with final imem_waddr=255; load_done asserts the cycle after the last WRITE.
- rst_n low after 2 of 4 data bytes; release; start; header 01 00; bytes AA BB CC DD -> single write addr0=0xDDCCBBAA (no stale bytes carried over); load_done=1.
